// File: rtl/or_nor_pkg.sv
// Shared definitions for the OR/NOR sweep controller and its reference model.
// Holds the FSM state encoding, the vector index geometry and the operation select codes.
package or_nor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int               IDX_W    = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;

  localparam logic OP_OR  = 1'b0;
  localparam logic OP_NOR = 1'b1;

endpackage

// File: rtl/or_nor_ref_model.sv
// Combinational golden OR/NOR evaluator.
// The controller uses it to judge results; benches can reuse it.
module or_nor_ref_model
  import or_nor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic exp
);

  always_comb begin
    if (sel == OP_NOR) begin
      exp = ~(a | b);
    end else begin
      exp = a | b;
    end
  end

endmodule

// File: rtl/or_nor_sweep_ctrl.sv
// Sweep controller: offers all eight {a,b,sel} vectors to a downstream OR/NOR stage,
// checks each returned result (or timeout) and reports error count, first failure and pass.
module or_nor_sweep_ctrl
  import or_nor_pkg::*;
#(
  parameter int REPEAT  = 1,
  parameter int TIMEOUT = 15,
  parameter int ERR_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             sel,
  output logic             op_valid,
  input  logic             op_ready,
  input  logic             res_valid,
  input  logic             res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_err_idx,
  output logic             first_err_vld
);

  localparam int                 SWEEP_W    = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int                 TMO_W      = $clog2(TIMEOUT + 1);
  localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(REPEAT - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [ERR_W-1:0]   ERR_MAX    = {ERR_W{1'b1}};

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SWEEP_W-1:0] sweep_q, sweep_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [IDX_W-1:0]   fidx_q, fidx_d;
  logic               fvld_q, fvld_d;
  logic               pass_q, pass_d;
  logic               op_valid_q, op_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               exp_s;
  logic               vec_end_s;
  logic               vec_fail_s;

  or_nor_ref_model u_ref (
    .a   (idx_q[2]),
    .b   (idx_q[1]),
    .sel (idx_q[0]),
    .exp (exp_s)
  );

  // State, counters, bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      sweep_q    <= '0;
      tmo_q      <= '0;
      err_q      <= '0;
      fidx_q     <= '0;
      fvld_q     <= 1'b0;
      pass_q     <= 1'b0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sweep_q    <= sweep_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      fidx_q     <= fidx_d;
      fvld_q     <= fvld_d;
      pass_q     <= pass_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state, vector sequencing and error accounting
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sweep_d    = sweep_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    fidx_d     = fidx_q;
    fvld_d     = fvld_q;
    pass_d     = pass_q;
    vec_end_s  = 1'b0;
    vec_fail_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
          sweep_d = '0;
          err_d   = '0;
          fidx_d  = '0;
          fvld_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (op_ready) begin
          state_d = ST_WAIT;
          tmo_d   = '0;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // A result arriving on the final timeout cycle still gets compared.
        if (res_valid) begin
          vec_end_s  = 1'b1;
          vec_fail_s = (res != exp_s);
        end else if (tmo_q == TMO_LAST) begin
          vec_end_s  = 1'b1;
          vec_fail_s = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (vec_end_s) begin
      if (vec_fail_s && (err_q != ERR_MAX)) begin
        err_d = err_q + ERR_W'(1);
      end else begin
        err_d = err_q;
      end
      if (vec_fail_s && !fvld_q) begin
        fvld_d = 1'b1;
        fidx_d = idx_q;
      end else begin
        fvld_d = fvld_q;
      end
      if (idx_q != LAST_IDX) begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = ST_ISSUE;
      end else if (sweep_q == SWEEP_LAST) begin
        state_d = ST_DONE;
        pass_d  = (err_d == '0);
      end else begin
        idx_d   = '0;
        sweep_d = sweep_q + SWEEP_W'(1);
        state_d = ST_ISSUE;
      end
    end else begin
      vec_fail_s = 1'b0;
    end
  end

  // Output decode from the upcoming state so the strobes come straight off flops
  always_comb begin
    op_valid_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      ST_ISSUE: begin
        op_valid_d = 1'b1;
        busy_d     = 1'b1;
      end
      ST_WAIT: begin
        busy_d = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        op_valid_d = 1'b0;
      end
    endcase
  end

  assign a             = idx_q[2];
  assign b             = idx_q[1];
  assign sel           = idx_q[0];
  assign op_valid      = op_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = fidx_q;
  assign first_err_vld = fvld_q;

endmodule

// File: tb/tb_or_nor_sweep_ctrl.sv
// Bench for or_nor_sweep_ctrl: a planned-timeline downstream emulator and model for the
// default instance, plus a reactive stuck-at-1 downstream for a REPEAT=3/ERR_W=3 instance.
module tb_or_nor_sweep_ctrl;

  localparam int         TMO     = 15;
  localparam int         NV      = 8;
  localparam logic [7:0] EXP_TAB = 8'h56;

  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, op_ready = 1'b0, res_valid = 1'b0, res = 1'b0;
  logic       a, b, sel, op_valid, busy, done, pass, first_err_vld;
  logic [3:0] err_count;
  logic [2:0] first_err_idx;

  logic       start2 = 1'b0, res_valid2 = 1'b0, pend2 = 1'b0;
  logic       a2, b2, sel2, op_valid2, busy2, done2, pass2, fvld2;
  logic [2:0] err2, fidx2;

  int  n_chk = 0, n_fail = 0, cyc = 0;
  bit  chk_en = 1'b0, lit_rst = 1'b0;

  // timeline of the sweep currently in flight
  bit  active = 1'b0, zero_flag = 1'b0;
  int  S, D, st_cyc;
  int  s_iss[NV], s_wt[NV], s_end[NV], rd[NV], lt[NV];
  bit  bd[NV], fl[NV];
  int  np_rd[NV], np_lt[NV];
  bit  np_bd[NV];
  int  h_err = 0, h_fidx = 0;
  bit  h_fvld = 1'b0, h_pass = 1'b0;

  int  d_cyc, d_err, d_fidx;
  bit  d_fvld, d_pass;
  int  d2_cnt = 0, d2_cyc = -1, d2_err, d2_fidx, acc2 = 0;
  bit  d2_fvld, d2_pass, d2_busy;

  always #5 clk = ~clk;

  or_nor_sweep_ctrl #(.REPEAT(1), .TIMEOUT(TMO), .ERR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sel(sel),
    .op_valid(op_valid), .op_ready(op_ready), .res_valid(res_valid), .res(res),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_vld(first_err_vld)
  );

  or_nor_sweep_ctrl #(.REPEAT(3), .TIMEOUT(TMO), .ERR_W(3)) dut_sat (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .sel(sel2),
    .op_valid(op_valid2), .op_ready(1'b1), .res_valid(res_valid2), .res(1'b1),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_idx(fidx2), .first_err_vld(fvld2)
  );

  function automatic void chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic bit vec_exp(input int k);
    bit o;
    o = (((k >> 2) | (k >> 1)) & 1) != 0;
    return ((k & 1) != 0) ? !o : o;
  endfunction

  task automatic model_at(input int c, output bit e_ov, output bit e_busy, output bit e_done,
                          output bit e_pass, output bit e_fvld, output bit e_idxv,
                          output int e_idx, output int e_err, output int e_fidx);
    int cnt;
    e_ov = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_idxv = zero_flag; e_idx = 0;
    e_err = h_err; e_fidx = h_fidx; e_fvld = h_fvld; e_pass = h_pass;
    if (active) begin
      cnt = 0; e_fvld = 1'b0; e_fidx = 0;
      for (int k = 0; k < NV; k++) begin
        if (fl[k] && s_end[k] <= c) begin
          cnt++;
          if (!e_fvld) begin e_fvld = 1'b1; e_fidx = k; end
        end
      end
      e_err  = (cnt > 15) ? 15 : cnt;
      e_pass = (c == D) && (cnt == 0);
      e_done = (c == D);
      for (int k = 0; k < NV; k++) begin
        if (c >= s_iss[k] && c < s_end[k]) begin
          e_busy = 1'b1; e_ov = (c < s_wt[k]); e_idxv = 1'b1; e_idx = k;
        end
      end
    end
  endtask

  // per-cycle comparison of the default instance against the model
  always @(negedge clk) begin
    bit e_ov, e_busy, e_done, e_pass, e_fvld, e_idxv;
    int e_idx, e_err, e_fidx;
    if (chk_en) begin
      model_at(cyc, e_ov, e_busy, e_done, e_pass, e_fvld, e_idxv, e_idx, e_err, e_fidx);
      chk("op_valid", int'(op_valid), int'(e_ov));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("pass", int'(pass), int'(e_pass));
      chk("err_count", int'(err_count), e_err);
      chk("first_err_vld", int'(first_err_vld), int'(e_fvld));
      if (e_fvld) chk("first_err_idx", int'(first_err_idx), e_fidx);
      if (e_idxv) chk("abs_operands", int'({a, b, sel}), e_idx);
      if (lit_rst) begin
        lit_rst = 1'b0;
        chk("reset_outputs", int'({a, b, sel, op_valid, busy, done, pass, first_err_vld,
                                  first_err_idx, err_count}), 0);
      end
      if (done === 1'b1) begin
        d_cyc = cyc; d_err = int'(err_count); d_fidx = int'(first_err_idx);
        d_fvld = first_err_vld; d_pass = pass;
      end
    end
  end

  // reactive stuck-at-1 downstream for the saturation instance
  initial begin
    forever begin
      @(negedge clk);
      res_valid2 = pend2;
      pend2 = (op_valid2 === 1'b1);
      if (op_valid2 === 1'b1) begin
        chk("sat_order", int'({a2, b2, sel2}), acc2 % 8);
        acc2++;
      end
      if (done2 === 1'b1) begin
        d2_cnt++; d2_cyc = cyc; d2_err = int'(err2); d2_fidx = int'(fidx2);
        d2_fvld = fvld2; d2_pass = pass2; d2_busy = busy2;
      end
    end
  end

  task automatic drive_ds(input int c);
    op_ready  = 1'($urandom_range(0, 1));
    res_valid = ($urandom_range(0, 3) == 0);
    res       = 1'($urandom_range(0, 1));
    if (active && c < D) begin
      for (int k = 0; k < NV; k++) begin
        if (c >= s_iss[k] && c < s_end[k]) begin
          if (c < s_wt[k]) begin
            op_ready = (c - s_iss[k] >= rd[k]);
          end else begin
            res_valid = (lt[k] <= TMO) && (c == s_wt[k] + lt[k] - 1);
            if (res_valid) res = vec_exp(k) ^ bd[k];
          end
        end
      end
    end
  endtask

  task automatic build(input int sc);
    int t;
    S = sc; t = sc;
    for (int k = 0; k < NV; k++) begin
      rd[k] = np_rd[k]; lt[k] = np_lt[k]; bd[k] = np_bd[k];
      s_iss[k] = t;
      s_wt[k]  = t + rd[k] + 1;
      s_end[k] = s_wt[k] + ((lt[k] > TMO) ? TMO : lt[k]);
      fl[k]    = (lt[k] > TMO) || bd[k];
      t = s_end[k];
    end
    D = t; active = 1'b1; zero_flag = 1'b0;
  endtask

  task automatic tick(input bit st, input bit rs);
    int c;
    bit go, e_ov, e_busy, e_done, e_pass, e_fvld, e_idxv;
    int e_idx, e_err, e_fidx;
    @(negedge clk);
    c = cyc;
    drive_ds(c);
    reset = rs;
    start = st | (active && (c == D || $urandom_range(0, 3) == 0));
    go = start && !rs && !active;
    if (go) st_cyc = c;
    @(posedge clk);
    cyc++;
    #1;
    if (rs) begin
      active = 1'b0; zero_flag = 1'b1;
      h_err = 0; h_fidx = 0; h_fvld = 1'b0; h_pass = 1'b0;
    end else if (go) begin
      build(cyc);
    end else if (active && cyc > D) begin
      model_at(D, e_ov, e_busy, e_done, e_pass, e_fvld, e_idxv, e_idx, e_err, e_fidx);
      h_err = e_err; h_fidx = e_fidx; h_fvld = e_fvld; h_pass = e_pass;
      active = 1'b0;
    end
  endtask

  task automatic set_ideal();
    for (int k = 0; k < NV; k++) begin np_rd[k] = 0; np_lt[k] = 1; np_bd[k] = 1'b0; end
  endtask

  task automatic run_sweep(input int gap);
    int guard;
    repeat (gap) tick(1'b0, 1'b0);
    d_cyc = -1;
    tick(1'b1, 1'b0);
    guard = 0;
    while (active && guard < 400) begin tick(1'b0, 1'b0); guard++; end
    if (active) begin
      chk("sweep_completes", int'(active), 0);
      active = 1'b0;
    end
  endtask

  task automatic lit(input string nm, input int len, input int err, input bit vld,
                     input int fidx, input bit pss);
    chk({nm, "_done_cycle"}, d_cyc - st_cyc, len);
    chk({nm, "_err_count"}, d_err, err);
    chk({nm, "_first_vld"}, int'(d_fvld), int'(vld));
    if (vld) chk({nm, "_first_idx"}, d_fidx, fidx);
    chk({nm, "_pass"}, int'(d_pass), int'(pss));
  endtask

  initial begin
    logic [7:0] tab;
    int n2, guard, r;
    tab = EXP_TAB;
    set_ideal();
    tick(1'b0, 1'b1);
    chk_en = 1'b1;
    lit_rst = 1'b1;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);

    // REPEAT=3, ERR_W=3, stuck-at-1 downstream
    n2 = cyc;
    start2 = 1'b1;
    tick(1'b0, 1'b0);
    start2 = 1'b0;
    repeat (60) tick(1'b0, 1'b0);
    chk("sat_done_pulses", d2_cnt, 1);
    chk("sat_done_cycle", d2_cyc - n2, 49);
    chk("sat_err_count", d2_err, 7);
    chk("sat_first_idx", d2_fidx, 0);
    chk("sat_first_vld", int'(d2_fvld), 1);
    chk("sat_pass", int'(d2_pass), 0);
    chk("sat_busy_at_done", int'(d2_busy), 0);
    chk("sat_vectors", acc2, 24);

    set_ideal();
    run_sweep(2);
    lit("ideal", 17, 0, 1'b0, 0, 1'b1);

    set_ideal();
    for (int k = 0; k < NV; k++) np_bd[k] = tab[k];
    run_sweep(1);
    lit("stuck0", 17, 4, 1'b1, 1, 1'b0);

    set_ideal();
    np_rd[5] = 3;
    run_sweep(0);
    lit("backpressure", 20, 0, 1'b0, 0, 1'b1);

    set_ideal();
    np_lt[3] = TMO + 5;
    run_sweep(3);
    lit("timeout", 31, 1, 1'b1, 3, 1'b0);

    // reset while idx 4 is being offered, then a clean re-run
    set_ideal();
    np_bd[0] = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    guard = 0;
    while (active && cyc < s_iss[4] && guard < 100) begin tick(1'b0, 1'b0); guard++; end
    tick(1'b0, 1'b1);
    lit_rst = 1'b1;
    tick(1'b0, 1'b0);
    set_ideal();
    run_sweep(1);
    lit("rerun", 17, 0, 1'b0, 0, 1'b1);

    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < NV; k++) begin
        np_rd[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        r = int'($urandom_range(0, 9));
        if (r <= 5)      np_lt[k] = int'($urandom_range(1, 3));
        else if (r <= 7) np_lt[k] = int'($urandom_range(4, TMO));
        else if (r == 8) np_lt[k] = TMO;
        else             np_lt[k] = TMO + 1;
        np_bd[k] = ($urandom_range(0, 5) == 0);
      end
      run_sweep(int'($urandom_range(0, 3)));
    end

    repeat (3) tick(1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
